// File: rtl/m_axil_master.sv
// AXI4-Lite master: turns a single-outstanding command/response handshake
// into AXI-Lite write (AW+W, then B) and read (AR, then R) transactions.
// Every AXI and response output is driven directly from a register.
// Optional build macro: M_AXIL_ALIGN_CHECK_EN -- when defined, commands whose
// address is not word aligned are answered locally with SLVERR and no bus
// transaction is issued.
module m_axil_master #(
    parameter int M_AXI_ADDR_WIDTH = 6,
    parameter int M_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    // local command / response side
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    // AXI-Lite write address / data / response channels
    output logic [M_AXI_ADDR_WIDTH-1:0]   AWADDR,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [M_AXI_DATA_WIDTH-1:0]   WDATA,
    output logic [M_AXI_DATA_WIDTH/8-1:0] WSTRB,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,
    // AXI-Lite read address / data channels
    output logic [M_AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [M_AXI_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY
);

    localparam int STRB_W = M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WADDR_DATA = 3'd1,
        S_WRESP      = 3'd2,
        S_RADDR      = 3'd3,
        S_RDATA      = 3'd4,
        S_RESP       = 3'd5
    } state_t;

    state_t                      state_reg, state_next;
    logic                        cmd_ready_reg, cmd_ready_next;
    logic [M_AXI_ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
    logic                        awvalid_reg, awvalid_next;
    logic [M_AXI_DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [STRB_W-1:0]           wstrb_reg, wstrb_next;
    logic                        wvalid_reg, wvalid_next;
    logic                        aw_done_reg, aw_done_next;
    logic                        w_done_reg, w_done_next;
    logic                        bready_reg, bready_next;
    logic [M_AXI_ADDR_WIDTH-1:0] araddr_reg, araddr_next;
    logic                        arvalid_reg, arvalid_next;
    logic                        rready_reg, rready_next;
    logic                        rsp_valid_reg, rsp_valid_next;
    logic                        rsp_write_reg, rsp_write_next;
    logic [M_AXI_DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]                  rsp_resp_reg, rsp_resp_next;

    // State and all output registers; reset abandons any bus transaction.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg     <= S_IDLE;
            cmd_ready_reg <= 1'b0;
            awaddr_reg    <= '0;
            awvalid_reg   <= 1'b0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            wvalid_reg    <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            araddr_reg    <= '0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= 2'b00;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            awaddr_reg    <= awaddr_next;
            awvalid_reg   <= awvalid_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            wvalid_reg    <= wvalid_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            bready_reg    <= bready_next;
            araddr_reg    <= araddr_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_write_reg <= rsp_write_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
        end
    end

    // Next-state and next-output decode; registers hold unless a step changes them.
    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        awaddr_next    = awaddr_reg;
        awvalid_next   = awvalid_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        wvalid_next    = wvalid_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        bready_next    = bready_reg;
        araddr_next    = araddr_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_write_next = rsp_write_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;

        case (state_reg)
            S_IDLE: begin
                // cmd_ready comes up one cycle after reset release
                cmd_ready_next = 1'b1;
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
`ifdef M_AXIL_ALIGN_CHECK_EN
                    if (cmd_addr[1:0] != 2'b00) begin
                        // misaligned: answer locally with SLVERR, no bus access
                        rsp_valid_next = 1'b1;
                        rsp_write_next = cmd_write;
                        rsp_rdata_next = '0;
                        rsp_resp_next  = 2'b10;
                        state_next     = S_RESP;
                    end else
`endif
                    if (cmd_write) begin
                        awaddr_next  = cmd_addr;
                        wdata_next   = cmd_wdata;
                        wstrb_next   = cmd_wstrb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                        state_next   = S_WADDR_DATA;
                    end else begin
                        araddr_next  = cmd_addr;
                        arvalid_next = 1'b1;
                        state_next   = S_RADDR;
                    end
                end
            end
            S_WADDR_DATA: begin
                // AW and W retire independently, in any order
                if (awvalid_reg && AWREADY) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (wvalid_reg && WREADY) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if (aw_done_next && w_done_next) begin
                    bready_next = 1'b1;
                    state_next  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (BVALID) begin
                    bready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_write_next = 1'b1;
                    rsp_rdata_next = '0;
                    rsp_resp_next  = BRESP;
                    state_next     = S_RESP;
                end
            end
            S_RADDR: begin
                if (ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (RVALID) begin
                    rready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_write_next = 1'b0;
                    rsp_rdata_next = RDATA;
                    rsp_resp_next  = RRESP;
                    state_next     = S_RESP;
                end
            end
            S_RESP: begin
                // response held stable; no new command until it is consumed
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_write = rsp_write_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;
    assign AWADDR    = awaddr_reg;
    assign AWVALID   = awvalid_reg;
    assign WDATA     = wdata_reg;
    assign WSTRB     = wstrb_reg;
    assign WVALID    = wvalid_reg;
    assign BREADY    = bready_reg;
    assign ARADDR    = araddr_reg;
    assign ARVALID   = arvalid_reg;
    assign RREADY    = rready_reg;

endmodule

// File: tb/tb_m_axil_master.sv
// Bench for m_axil_master: directed steps followed by random commands against
// a delay-configurable AXI-Lite slave. Expected responses, latencies and
// per-channel cycle counts come from a memory model and the slave timing.
// Honours M_AXIL_ALIGN_CHECK_EN the same way the design does.
module tb_m_axil_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [5:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    m_axil_master dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- slave with programmable per-channel delays ----------
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] slv_bresp = 2'b00, slv_rresp = 2'b00;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic aw_got, w_got, ar_got;
    logic [5:0]  aw_addr_l, ar_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    logic [31:0] slave_mem [16] = '{default: '0};

    assign AWREADY = (aw_wait >= aw_delay);
    assign WREADY  = (w_wait >= w_delay);
    assign ARREADY = (ar_wait >= ar_delay);
    assign BVALID  = aw_got && w_got && (b_wait >= b_delay);
    assign BRESP   = slv_bresp;
    assign RVALID  = ar_got && (r_wait >= r_delay);
    assign RDATA   = slave_mem[ar_addr_l[5:2]];
    assign RRESP   = slv_rresp;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
        end else begin
            if (AWVALID && !aw_got) begin
                if (AWREADY) begin
                    aw_got <= 1'b1; aw_addr_l <= AWADDR; aw_wait <= 0;
                end else aw_wait <= aw_wait + 1;
            end
            if (WVALID && !w_got) begin
                if (WREADY) begin
                    w_got <= 1'b1; w_data_l <= WDATA; w_strb_l <= WSTRB; w_wait <= 0;
                end else w_wait <= w_wait + 1;
            end
            if (aw_got && w_got) begin
                if (BVALID) begin
                    if (BREADY) begin
                        slave_mem[aw_addr_l[5:2]] <= apply_strb(slave_mem[aw_addr_l[5:2]], w_data_l, w_strb_l);
                        aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
                    end
                end else b_wait <= b_wait + 1;
            end
            if (ARVALID && !ar_got) begin
                if (ARREADY) begin
                    ar_got <= 1'b1; ar_addr_l <= ARADDR; ar_wait <= 0;
                end else ar_wait <= ar_wait + 1;
            end
            if (ar_got) begin
                if (RVALID) begin
                    if (RREADY) begin ar_got <= 1'b0; r_wait <= 0; end
                end else r_wait <= r_wait + 1;
            end
        end
    end

    // ---------------- bus monitor: handshakes, active cycles, stability ----
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int awv_cyc = 0, wv_cyc = 0, bready_cyc = 0, arv_cyc = 0, rready_cyc = 0;
    int viol = 0;
    logic awv_q, awr_q, wv_q, wr_q, arv_q, arr_q;
    logic [5:0] awaddr_q, araddr_q;
    logic [31:0] wdata_q;
    logic [3:0] wstrb_q;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awv_q <= 1'b0; wv_q <= 1'b0; arv_q <= 1'b0;
            awr_q <= 1'b0; wr_q <= 1'b0; arr_q <= 1'b0;
        end else begin
            if (AWVALID && AWREADY) aw_hs <= aw_hs + 1;
            if (WVALID && WREADY)   w_hs <= w_hs + 1;
            if (BVALID && BREADY)   b_hs <= b_hs + 1;
            if (ARVALID && ARREADY) ar_hs <= ar_hs + 1;
            if (RVALID && RREADY)   r_hs <= r_hs + 1;
            if (AWVALID) awv_cyc <= awv_cyc + 1;
            if (WVALID)  wv_cyc <= wv_cyc + 1;
            if (BREADY)  bready_cyc <= bready_cyc + 1;
            if (ARVALID) arv_cyc <= arv_cyc + 1;
            if (RREADY)  rready_cyc <= rready_cyc + 1;
            if ((awv_q && !awr_q && (!AWVALID || AWADDR !== awaddr_q)) ||
                (wv_q && !wr_q && (!WVALID || WDATA !== wdata_q || WSTRB !== wstrb_q)) ||
                (arv_q && !arr_q && (!ARVALID || ARADDR !== araddr_q)))
                viol <= viol + 1;
            awv_q <= AWVALID; awr_q <= AWREADY; awaddr_q <= AWADDR;
            wv_q <= WVALID; wr_q <= WREADY; wdata_q <= WDATA; wstrb_q <= WSTRB;
            arv_q <= ARVALID; arr_q <= ARREADY; araddr_q <= ARADDR;
        end
    end

    // ---------------- reference model and checking ------------------------
    logic [31:0] ref_mem [16] = '{default: '0};
    logic        p_wr;
    logic [5:0]  p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_strb;
    int acc_cyc;
    int s_aw, s_w, s_b, s_ar, s_r, s_awv, s_wv, s_brd, s_arv, s_rrd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a command (called at a negedge); returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [5:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = data; cmd_wstrb = strb;
        p_wr = wr; p_addr = addr; p_data = data; p_strb = strb;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge ACLK); n++;
        end
        if (cmd_ready !== 1'b1) begin
            check("accept_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        s_aw = aw_hs; s_w = w_hs; s_b = b_hs; s_ar = ar_hs; s_r = r_hs;
        s_awv = awv_cyc; s_wv = wv_cyc; s_brd = bready_cyc; s_arv = arv_cyc; s_rrd = rready_cyc;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    // Wait for and check the response to the last issued command, then consume it.
    task automatic finish_rsp(input int hold);
        int n, lat, exp_lat;
        logic err_path, do_w, do_r;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        err_path = 1'b0;
`ifdef M_AXIL_ALIGN_CHECK_EN
        err_path = (p_addr[1:0] != 2'b00);
`endif
        do_w = p_wr && !err_path;
        do_r = !p_wr && !err_path;
        if (err_path) begin
            exp_rdata = 32'h0; exp_resp = 2'b10; exp_lat = 1;
        end else if (p_wr) begin
            exp_rdata = 32'h0; exp_resp = slv_bresp;
            exp_lat = ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay + 3;
        end else begin
            exp_rdata = ref_mem[p_addr[5:2]]; exp_resp = slv_rresp;
            exp_lat = ar_delay + r_delay + 3;
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin
            check("cmd_ready_busy", cmd_ready, 0);
            @(negedge ACLK); n++;
        end
        if (rsp_valid !== 1'b1) begin
            check("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        lat = cyc - acc_cyc;
        check("latency", lat, exp_lat);
        check("rsp_write", rsp_write, p_wr);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_resp", rsp_resp, exp_resp);
        check("cmd_ready_in_resp", cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge ACLK);
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_rdata", rsp_rdata, exp_rdata);
            check("rsp_hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        check("rsp_consumed", rsp_valid, 0);
        check("cmd_ready_after", cmd_ready, 1);
        check("aw_count", aw_hs - s_aw, do_w ? 1 : 0);
        check("w_count", w_hs - s_w, do_w ? 1 : 0);
        check("b_count", b_hs - s_b, do_w ? 1 : 0);
        check("ar_count", ar_hs - s_ar, do_r ? 1 : 0);
        check("r_count", r_hs - s_r, do_r ? 1 : 0);
        check("awvalid_cycles", awv_cyc - s_awv, do_w ? aw_delay + 1 : 0);
        check("wvalid_cycles", wv_cyc - s_wv, do_w ? w_delay + 1 : 0);
        check("bready_cycles", bready_cyc - s_brd, do_w ? b_delay + 1 : 0);
        check("arvalid_cycles", arv_cyc - s_arv, do_r ? ar_delay + 1 : 0);
        check("rready_cycles", rready_cyc - s_rrd, do_r ? r_delay + 1 : 0);
        if (do_w) check("awaddr_seen", aw_addr_l, p_addr);
        if (do_r) check("araddr_seen", ar_addr_l, p_addr);
        check("stability", viol, 0);
        if (do_w) ref_mem[p_addr[5:2]] = apply_strb(ref_mem[p_addr[5:2]], p_data, p_strb);
        $display("txn wr=%0b addr=%02h lat=%0d resp=%0b rdata=%08h", p_wr, p_addr, lat, rsp_resp, rsp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        // reset state
        check("reset_handshakes", {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready, rsp_valid}, 0);
        check("reset_regs", {AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write}, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("cmd_ready_after_reset", cmd_ready, 1);

        // zero-wait write then read-back of 0x08
        issue(1'b1, 6'h08, 32'hA5A5_1234, 4'hF);
        check("aw_w_valid_c1", {AWVALID, WVALID}, 2'b11);
        check("awaddr_c1", AWADDR, 6'h08);
        check("wdata_c1", WDATA, 32'hA5A5_1234);
        check("wstrb_c1", WSTRB, 4'hF);
        finish_rsp(0);
        issue(1'b0, 6'h08, 32'h0, 4'h0);
        finish_rsp(0);

        // AWREADY late by 3, WREADY immediate
        aw_delay = 3;
        issue(1'b1, 6'h3C, 32'hDEAD_BEEF, 4'h5);
        finish_rsp(1);
        aw_delay = 0;

        // read 0x3C with RVALID 5 cycles late and SLVERR
        r_delay = 5; slv_rresp = 2'b10;
        issue(1'b0, 6'h3C, 32'h0, 4'h0);
        finish_rsp(0);
        check("partial_strobe_word", ref_mem[15], 32'h00AD_00EF);
        r_delay = 0; slv_rresp = 2'b00;

        // back-to-back: second command waits while response is held 4 cycles
        issue(1'b1, 6'h20, 32'h1357_9BDF, 4'hF);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h20;
        finish_rsp(4);
        issue(1'b0, 6'h20, 32'h0, 4'h0);
        check("b2b_arvalid_next", ARVALID, 1);
        finish_rsp(0);

        // reset pulsed while waiting for B
        b_delay = 5;
        issue(1'b1, 6'h10, 32'hCAFE_F00D, 4'hF);
        n = 0;
        while (BREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
        check("reached_wresp", BREADY, 1);
        #2 ARESET = 1'b1;
        #1 check("async_reset_handshakes", {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready, rsp_valid}, 0);
        check("async_reset_awaddr", AWADDR, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        b_delay = 0;
        @(negedge ACLK);
        check("cmd_ready_post_pulse", cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            check("no_rsp_after_abort", rsp_valid, 0);
            @(negedge ACLK);
        end
        issue(1'b0, 6'h10, 32'h0, 4'h0);
        finish_rsp(0);

`ifdef M_AXIL_ALIGN_CHECK_EN
        issue(1'b0, 6'h06, 32'h0, 4'h0);
        finish_rsp(0);
`endif

        // random commands, random slave timing and response codes
        for (int t = 0; t < 40; t++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay = $urandom_range(0, 3);
            slv_bresp = 2'($urandom_range(0, 3)); slv_rresp = 2'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
            finish_rsp($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_axil_master.md
Name: m_axil_master

Overview:
AXI4-Lite master. It converts a simple single-outstanding command/response interface into AXI-Lite write and read transactions. It is the initiator side for the team's AXI-Lite register slaves and sits between a local controller (sequencer, CPU bridge, testbench driver) and the AXI-Lite interconnect. Only one transaction is in flight at a time.

Parameters:
M_AXI_ADDR_WIDTH, 6, AXI byte address width.
M_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32 (WSTRB width is 4).

Ports:
ACLK  in  1  clock, rising edge.
ARESET  in  1  reset, asynchronous, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  ADDR_W  byte address.
cmd_wdata  in  DATA_W  write data.
cmd_wstrb  in  DATA_W/8  write byte strobes.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
rsp_write  out  1  response belongs to a write.
rsp_rdata  out  DATA_W  read data (0 for writes).
rsp_resp  out  2  BRESP or RRESP as received.
AWADDR/AWVALID out, AWREADY in  ADDR_W/1/1  write address channel.
WDATA/WSTRB/WVALID out, WREADY in  DATA_W/DATA_W/8/1/1  write data channel.
BRESP in 2, BVALID in 1, BREADY out 1  write response channel.
ARADDR/ARVALID out, ARREADY in  ADDR_W/1/1  read address channel.
RDATA in DATA_W, RRESP in 2, RVALID in 1, RREADY out 1  read data channel.

Behaviour:
- Reset (async, any state): state=IDLE. All VALID/READY outputs 0. AWADDR, ARADDR, WDATA, WSTRB, rsp_* = 0. Any in-flight bus transaction is abandoned.
- FSM states: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP. All outputs come straight from registers.
- IDLE: cmd_ready=1.
  - Accept with cmd_write=1: latch addr, data and strobes; next state WADDR_DATA.
  - Accept with cmd_write=0: latch addr; next state RADDR.
- WADDR_DATA:
  - AWVALID and WVALID both rise in the cycle after acceptance.
  - Each VALID drops independently on its own handshake, tracked by aw_done/w_done flags. AW and W may complete in the same or different cycles, in either order.
  - Once both are done, next state WRESP.
  - VALID is never withdrawn before its handshake; address and data stay stable while VALID=1.
- WRESP: BREADY=1. On BVALID, capture BRESP, set rsp_write=1 and rsp_rdata=0, go to RESP.
- RADDR: ARVALID=1 until ARREADY, then go to RDATA.
- RDATA: RREADY=1. On RVALID, capture RDATA/RRESP, set rsp_write=0, go to RESP.
- RESP: rsp_valid=1, held stable until rsp_ready, then return to IDLE.
  - cmd_ready stays 0 in RESP; there is no command/response overlap.
- Minimum latency with a zero-wait slave and rsp_ready=1:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, rsp_valid at cycle 3, cmd_ready again at cycle 4.
  - Read: accept at cycle 0, AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- BREADY and RREADY are asserted only in WRESP/RDATA. A BVALID or RVALID arriving in any other state is ignored.
- Non-OKAY responses are passed through unchanged; no retry.

Optional Feature:
M_AXIL_ALIGN_CHECK_EN
- Defined: a command with cmd_addr[1:0]!=0 is accepted but issues no AXI transaction. FSM goes IDLE->RESP with rsp_resp=2'b10 (SLVERR), rsp_rdata=0 and rsp_write=cmd_write. rsp_valid appears in the cycle after acceptance.
- Undefined: the address is forwarded unchanged, including its low bits.

Test Plan:
- Write addr 0x08, data 0xA5A5_1234, strb 0xF, zero-wait slave -> AWADDR=0x08, WDATA=0xA5A5_1234 at cycle 1; rsp_valid at cycle 3 with rsp_write=1 and rsp_resp=00. A follow-up read of 0x08 returns rsp_rdata=0xA5A5_1234.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID stays high 4 cycles with AWADDR stable. Exactly one B accepted; one response.
- Read of 0x3C with RVALID delayed 5 cycles and RRESP=2'b10 -> RREADY held high throughout; rsp_rdata = the slave's RDATA, rsp_resp=10.
- Back-to-back: a second cmd_valid held high during a transaction with rsp_ready=0 for 4 cycles -> cmd_ready stays 0 until the response is consumed; the second command then starts in the next cycle.
- ARESET pulsed mid-WRESP -> all VALID/READY outputs 0 immediately (asynchronous), cmd_ready=1 in the first cycle after release, no rsp_valid.
- With M_AXIL_ALIGN_CHECK_EN defined, read of 0x06 -> no ARVALID; rsp_valid at cycle 1 with rsp_resp=10 and rsp_rdata=0.
